// File: rtl/fht_unload.sv
`default_nettype none
// ============================================================================
//  Module   : fht_unload
//  Purpose  : Result reader for the FHT core. Waits for the core ready edge,
//             sweeps the four result banks with one shared read address and
//             serialises each 4-word group onto a valid/ready stream in
//             natural point order (point = 4*addr + bank).
//  Revision : 1.0  initial release
// ============================================================================
module fht_unload #(
    parameter int D_BIT     = 16,
    parameter int A_BIT     = 8,
    parameter int BANK_SIZE = 256,
    parameter int RD_LAT    = 1
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iFHT_RDY,
    output logic [A_BIT-1:0]        oADDR_RD,
    input  logic signed [D_BIT-1:0] iBANK_0,
    input  logic signed [D_BIT-1:0] iBANK_1,
    input  logic signed [D_BIT-1:0] iBANK_2,
    input  logic signed [D_BIT-1:0] iBANK_3,
    output logic signed [D_BIT-1:0] oDATA,
    output logic                    oVALID,
    input  logic                    iREADY,
    output logic                    oLAST,
    output logic [A_BIT+1:0]        oIDX,
    output logic                    oBUSY,
    output logic                    oDONE
);

    localparam logic [A_BIT-1:0] c_LAST_ADDR = A_BIT'(BANK_SIZE - 1);
    localparam logic [1:0]       c_RD_LAT    = 2'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STREAM = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_rdy_q;
    logic                    w_start;
    logic                    w_launch;
    logic                    w_capture;
    logic                    w_accept;
    logic [1:0]              r_cnt;          // read-latency / prefetch countdown
    logic [A_BIT-1:0]        r_addr;         // address currently on the bank ports
    logic [A_BIT-1:0]        r_buf_addr;     // address the hold buffer came from
    logic [1:0]              r_ptr;          // word (bank) pointer into the buffer
    logic                    r_all_fetched;  // last address already captured
    logic signed [D_BIT-1:0] r_buf [4];

    assign w_start  = iFHT_RDY & ~r_rdy_q;
    assign w_accept = (r_state == S_STREAM) & iREADY;

    // Edge-detect delay; with the clock running through reset it tracks the
    // live level, so a ready flag already high at release is not an edge.
    always_ff @(posedge iCLK) begin
        r_rdy_q <= iFHT_RDY;
    end

    // State register
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        oVALID      = 1'b0;
        oBUSY       = 1'b1;
        oDONE       = 1'b0;
        case (r_state)
            S_IDLE: begin
                oBUSY = 1'b0;
                if (w_start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_cnt == 2'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                oVALID = 1'b1;
                if (iREADY && (r_ptr == 2'd3)) begin
                    if (r_all_fetched)       w_state_nxt = S_FINISH;
                    else if (r_cnt == 2'd0)  w_capture   = 1'b1;   // prefetch ready: no bubble
                    else                     w_state_nxt = S_FETCH;
                end
            end
            S_FINISH: begin
                oDONE       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address sweep, latency counter and hold buffer
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_addr        <= '0;
            r_buf_addr    <= '0;
            r_cnt         <= 2'd0;
            r_ptr         <= 2'd0;
            r_all_fetched <= 1'b0;
            for (int k = 0; k < 4; k++) r_buf[k] <= '0;
        end else if (w_launch) begin
            r_addr        <= '0;
            r_buf_addr    <= '0;
            r_cnt         <= c_RD_LAT;
            r_ptr         <= 2'd0;
            r_all_fetched <= 1'b0;
        end else if (w_capture) begin
            r_buf[0]   <= iBANK_0;
            r_buf[1]   <= iBANK_1;
            r_buf[2]   <= iBANK_2;
            r_buf[3]   <= iBANK_3;
            r_buf_addr <= r_addr;
            r_ptr      <= 2'd0;
            // Launch the prefetch of the next group right away so its read
            // latency overlaps the four stream cycles of this one.
            if (r_addr == c_LAST_ADDR) begin
                r_all_fetched <= 1'b1;
                r_cnt         <= 2'd0;
            end else begin
                r_addr <= r_addr + 1'b1;
                r_cnt  <= c_RD_LAT;
            end
        end else begin
            if (r_cnt != 2'd0)         r_cnt  <= r_cnt - 2'd1;
            if (w_accept)              r_ptr  <= r_ptr + 2'd1;
            if (r_state == S_FINISH)   r_addr <= '0;
        end
    end

    assign oADDR_RD = r_addr;
    assign oIDX     = {r_buf_addr, r_ptr};
    assign oDATA    = oVALID ? r_buf[r_ptr] : '0;
    assign oLAST    = oVALID && (r_buf_addr == c_LAST_ADDR) && (r_ptr == 2'd3);

endmodule
`default_nettype wire

// File: tb/tb_fht_unload.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fht_unload
//  Purpose  : Scoreboard bench for fht_unload. Two instances (RD_LAT=1 and
//             RD_LAT=3) read from bank models holding 100*bank + addr.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fht_unload;

    localparam int D_BIT     = 16;
    localparam int A_BIT     = 3;
    localparam int BANK_SIZE = 8;
    localparam int NW        = 4 * BANK_SIZE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    rdy   [2];
    logic                    ready [2];
    logic [A_BIT-1:0]        addr  [2];
    logic signed [D_BIT-1:0] bank  [2][4];
    logic signed [D_BIT-1:0] data  [2];
    logic                    valid [2];
    logic                    last  [2];
    logic [A_BIT+1:0]        idx   [2];
    logic                    busy  [2];
    logic                    done  [2];

    int n_checks = 0;
    int n_pass   = 0;

    fht_unload #(.D_BIT(D_BIT), .A_BIT(A_BIT), .BANK_SIZE(BANK_SIZE), .RD_LAT(1)) u_dut_lat1 (
        .iCLK(clk), .iRESET(rst), .iFHT_RDY(rdy[0]), .oADDR_RD(addr[0]),
        .iBANK_0(bank[0][0]), .iBANK_1(bank[0][1]), .iBANK_2(bank[0][2]), .iBANK_3(bank[0][3]),
        .oDATA(data[0]), .oVALID(valid[0]), .iREADY(ready[0]), .oLAST(last[0]),
        .oIDX(idx[0]), .oBUSY(busy[0]), .oDONE(done[0])
    );

    fht_unload #(.D_BIT(D_BIT), .A_BIT(A_BIT), .BANK_SIZE(BANK_SIZE), .RD_LAT(3)) u_dut_lat3 (
        .iCLK(clk), .iRESET(rst), .iFHT_RDY(rdy[1]), .oADDR_RD(addr[1]),
        .iBANK_0(bank[1][0]), .iBANK_1(bank[1][1]), .iBANK_2(bank[1][2]), .iBANK_3(bank[1][3]),
        .oDATA(data[1]), .oVALID(valid[1]), .iREADY(ready[1]), .oLAST(last[1]),
        .oIDX(idx[1]), .oBUSY(busy[1]), .oDONE(done[1])
    );

    // Bank models: address pipelined by the read latency, word = 100*bank + addr
    logic [A_BIT-1:0] pipe1    = '0;
    logic [A_BIT-1:0] pipe3 [3] = '{default: '0};
    always @(posedge clk) begin
        pipe1    <= addr[0];
        pipe3[0] <= addr[1];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bank[0][k] = 16'(100 * k + int'(pipe1));
            bank[1][k] = 16'(100 * k + int'(pipe3[2]));
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard queues hold the expected point index n of each word
    int q0[$];
    int q1[$];
    function automatic void push_exp(input int d, input int n);
        if (d == 0) q0.push_back(n); else q1.push_back(n);
    endfunction
    function automatic int pop_exp(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction
    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Monitor: compares every accepted word, stall stability, address order
    int acc      [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    logic pv [2] = '{1'b0, 1'b0};
    logic pr [2] = '{1'b0, 1'b0};
    int   pd [2] = '{0, 0};
    int   pi [2] = '{0, 0};
    int   pa [2] = '{0, 0};
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pv[d] = 1'b0;
                pa[d] = 0;
            end else begin
                if (pv[d] && !pr[d]) begin
                    check($sformatf("stall_valid_hold%0d", d), int'(valid[d]), 1);
                    check($sformatf("stall_data_hold%0d", d), int'(data[d]), pd[d]);
                    check($sformatf("stall_idx_hold%0d", d), int'(idx[d]), pi[d]);
                end
                if (busy[d]) check($sformatf("addr_monotonic%0d", d), int'(int'(addr[d]) >= pa[d]), 1);
                if (done[d]) done_cnt[d]++;
                if (valid[d] && ready[d]) begin
                    if (q_size(d) == 0) begin
                        check($sformatf("unexpected_word%0d", d), int'(idx[d]), -1);
                    end else begin
                        int n;
                        n = pop_exp(d);
                        // point n = 4*addr + bank  ->  value 100*bank + addr
                        check($sformatf("data%0d_n%0d", d, n), int'(data[d]), 100 * (n % 4) + n / 4);
                        check($sformatf("idx%0d_n%0d", d, n), int'(idx[d]), n);
                        check($sformatf("last%0d_n%0d", d, n), int'(last[d]), int'(n == NW - 1));
                    end
                    acc[d]++;
                end
                pv[d] = valid[d];
                pr[d] = ready[d];
                pd[d] = int'(data[d]);
                pi[d] = int'(idx[d]);
                pa[d] = int'(addr[d]);
            end
        end
    end

    task automatic check_zero(input int d, input string tag);
        check({tag, "_addr"},  int'(addr[d]),  0);
        check({tag, "_data"},  int'(data[d]),  0);
        check({tag, "_valid"}, int'(valid[d]), 0);
        check({tag, "_last"},  int'(last[d]),  0);
        check({tag, "_idx"},   int'(idx[d]),   0);
        check({tag, "_busy"},  int'(busy[d]),  0);
        check({tag, "_done"},  int'(done[d]),  0);
    endtask

    // Full unload with iREADY=1: latency, gap-free stream, single done pulse
    task automatic run_full(input int d, input int lat, input string tag);
        int cyc;
        int gaps;
        int d0;
        d0 = done_cnt[d];
        for (int n = 0; n < NW; n++) push_exp(d, n);
        ready[d] = 1'b1;
        rdy[d]   = 1'b1;
        cyc      = 0;
        while (!valid[d] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_first_valid_latency"}, cyc, lat + 2);
        gaps = 0;
        for (int i = 1; i < NW; i++) begin
            @(posedge clk); #1;
            if (!valid[d]) gaps++;
        end
        check({tag, "_stream_gaps"}, gaps, 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, int'(done[d]), 1);
        check({tag, "_valid_after_last"}, int'(valid[d]), 0);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, int'(done[d]), 0);
        check({tag, "_busy_end"}, int'(busy[d]), 0);
        check({tag, "_addr_end"}, int'(addr[d]), 0);
        @(negedge clk);
        check({tag, "_done_count"}, done_cnt[d] - d0, 1);
        check({tag, "_words_left"}, q_size(d), 0);
        rdy[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int d0;
        int a0;
        int cnt;
        int i;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rdy[d]   = 1'b0;
            ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "reset_lat1");
        check_zero(1, "reset_lat3");
        rst = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid[0] || valid[1]) cnt++;
        end
        check("idle_no_valid", cnt, 0);

        run_full(0, 1, "full_lat1");
        run_full(1, 3, "full_lat3");

        // Backpressure: iREADY pattern 1,0,0,1
        d0 = done_cnt[0];
        a0 = acc[0];
        for (int n = 0; n < NW; n++) push_exp(0, n);
        rdy[0] = 1'b1;
        i = 0;
        while (done_cnt[0] == d0 && i < 500) begin
            ready[0] = pat[i % 4];
            @(posedge clk); #1;
            i++;
        end
        ready[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_done_count", done_cnt[0] - d0, 1);
        check("bp_words", acc[0] - a0, NW);
        check("bp_words_left", q_size(0), 0);
        check("bp_busy_end", int'(busy[0]), 0);
        rdy[0] = 1'b0;
        @(posedge clk); #1;

        // Ready flag re-pulsed mid-unload and held high: must be ignored
        d0 = done_cnt[0];
        a0 = acc[0];
        for (int n = 0; n < NW; n++) push_exp(0, n);
        rdy[0] = 1'b1;
        i = 0;
        while (acc[0] - a0 < 10 && i < 100) begin @(posedge clk); #1; i++; end
        rdy[0] = 1'b0;
        @(posedge clk); #1;
        rdy[0] = 1'b1;
        i = 0;
        while (done_cnt[0] == d0 && i < 200) begin @(posedge clk); #1; i++; end
        repeat (30) @(posedge clk);
        #1;
        check("repulse_done_count", done_cnt[0] - d0, 1);
        check("repulse_words", acc[0] - a0, NW);
        check("repulse_words_left", q_size(0), 0);
        check("repulse_busy_end", int'(busy[0]), 0);
        rdy[0] = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset right after word 13 is accepted
        a0 = acc[0];
        for (int n = 0; n < NW; n++) push_exp(0, n);
        rdy[0] = 1'b1;
        i = 0;
        while (acc[0] - a0 < 14 && i < 100) begin @(posedge clk); #1; i++; end
        check("midreset_words_before", acc[0] - a0, 14);
        rst = 1'b1;
        #1;
        check_zero(0, "midreset");
        q0.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (valid[0] || busy[0]) cnt++;
        end
        check("midreset_level_no_start", cnt, 0);
        rdy[0] = 1'b0;
        @(posedge clk); #1;
        run_full(0, 1, "restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
